// File: rtl/bsg_cover_pkg.sv
// bsg_cover_pkg
//   Shared definitions for the coverage realigner and the host-side config
//   CSR decoder. The helper functions stand in for the BSG width macros so
//   that every file derives port and register widths the same way.
//   No ports (package only).

package bsg_cover_pkg;

    // Bits needed to hold the value x itself (0..x inclusive).
    function automatic int bsg_width(input int x);
        return $clog2(x + 1);
    endfunction

    // Index width that never collapses to zero bits, even for a single entry.
    function automatic int bsg_safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    // Default geometry, shared with the CSR decoder that builds config words.
    localparam int cover_num_chan_gp  = 4;
    localparam int cover_max_depth_gp = 8;
    localparam int cover_chan_w_gp    = bsg_safe_clog2(cover_num_chan_gp);
    localparam int cover_depth_w_gp   = bsg_width(cover_max_depth_gp);

    // One config write: which channel, and its new delay in beats.
    typedef struct packed {
        logic [cover_chan_w_gp-1:0]  chan;
        logic [cover_depth_w_gp-1:0] depth;
    } bsg_cover_realign_cfg_s;

endpackage

// File: rtl/bsg_cover_realign_ring.sv
// bsg_cover_realign_ring
//   Storage for one channel of the realigner: a max_depth_p-entry ring of
//   chan_width_p-bit beats, the channel's programmed delay, and the wrapped
//   read index. The write pointer is owned by the parent and shared by all
//   channels.
// Ports
//   clk_i, reset_i  clock, synchronous active-high reset (clears depth only)
//   wptr_i          shared ring write pointer
//   v_i             beat accepted; writes data_i at wptr_i
//   data_i          this channel's input chunk
//   cfg_we_i        load a new depth for this channel
//   cfg_depth_i     requested depth (clamped to max_depth_p here)
//   data_o          delayed chunk, or data_i directly when depth is 0
//   depth_o         current programmed depth

module bsg_cover_realign_ring
    import bsg_cover_pkg::*;
#(
    parameter  int chan_width_p = 8,
    parameter  int max_depth_p  = 8,
    localparam int depth_w_lp   = bsg_width(max_depth_p),
    localparam int ptr_w_lp     = bsg_safe_clog2(max_depth_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [ptr_w_lp-1:0]     wptr_i,
    input  logic                    v_i,
    input  logic [chan_width_p-1:0] data_i,
    input  logic                    cfg_we_i,
    input  logic [depth_w_lp-1:0]   cfg_depth_i,
    output logic [chan_width_p-1:0] data_o,
    output logic [depth_w_lp-1:0]   depth_o
);

    logic [chan_width_p-1:0] mem_q [max_depth_p];
    logic [depth_w_lp-1:0]   depth_q, depth_d;
    logic [depth_w_lp-1:0]   wptrExt;
    logic [depth_w_lp-1:0]   rdIdx;

    // Ring contents are deliberately not reset; the parent masks stale
    // entries with v_o until enough beats have been written.
    always_ff @(posedge clk_i) begin
        if (v_i) begin
            mem_q[wptr_i] <= data_i;
        end
    end

    // Requests deeper than the ring are clamped to the full ring depth.
    always_comb begin
        depth_d = depth_q;
        if (cfg_we_i) begin
            depth_d = (cfg_depth_i > depth_w_lp'(max_depth_p))
                    ? depth_w_lp'(max_depth_p) : cfg_depth_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // (wptr - depth) mod max_depth_p with an explicit wrap. Intermediate
    // overflow in the add is harmless because the final result is < max.
    // depth == max lands on wptr: the oldest entry, read before this beat
    // overwrites it.
    always_comb begin
        wptrExt = depth_w_lp'(wptr_i);
        if (wptrExt >= depth_q) begin
            rdIdx = wptrExt - depth_q;
        end else begin
            rdIdx = wptrExt + depth_w_lp'(max_depth_p) - depth_q;
        end
    end

    always_comb begin
        data_o = data_i;
        if (depth_q != '0) begin
            data_o = mem_q[rdIdx[ptr_w_lp-1:0]];
        end
    end

    assign depth_o = depth_q;

endmodule

// File: rtl/bsg_cover_realign_dyn.sv
// bsg_cover_realign_dyn
//   Delays each of num_chan_p coverage channels by its own programmable
//   number of accepted beats, so stage taps line up before the coverage
//   FIFO/packer. Delay counts v_i beats, not clocks, so stalls do not break
//   the alignment.
// Ports
//   clk_i, reset_i  clock, synchronous active-high reset
//   cfg_v_i         write one channel's depth register
//   cfg_chan_i      channel to configure (out-of-range writes are ignored)
//   cfg_depth_i     new delay in beats (clamped to max_depth_p)
//   v_i             input beat valid; advances every ring
//   data_i          channel c at [c*chan_width_p +: chan_width_p]
//   v_o             aligned beat valid (all channels hold real history)
//   data_o          realigned data, same packing as data_i
//   primed_o        history is deep enough for the current configuration

module bsg_cover_realign_dyn
    import bsg_cover_pkg::*;
#(
    parameter  int num_chan_p   = 4,
    parameter  int chan_width_p = 8,
    parameter  int max_depth_p  = 8,
    localparam int depth_w_lp   = bsg_width(max_depth_p),
    localparam int chan_w_lp    = bsg_safe_clog2(num_chan_p),
    localparam int ptr_w_lp     = bsg_safe_clog2(max_depth_p)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               cfg_v_i,
    input  logic [chan_w_lp-1:0]               cfg_chan_i,
    input  logic [depth_w_lp-1:0]              cfg_depth_i,
    input  logic                               v_i,
    input  logic [num_chan_p*chan_width_p-1:0] data_i,
    output logic                               v_o,
    output logic [num_chan_p*chan_width_p-1:0] data_o,
    output logic                               primed_o
);

    logic [ptr_w_lp-1:0]   wptr_q, wptr_d;
    logic [depth_w_lp-1:0] fillCnt_q, fillCnt_d;
    logic [depth_w_lp-1:0] chanDepth [num_chan_p];
    logic [depth_w_lp-1:0] maxDepth;
    logic                  cfgAccept;

    // Writes addressed past the last channel are dropped entirely, so they
    // must not disturb the fill count either.
    assign cfgAccept = cfg_v_i & (int'(cfg_chan_i) < num_chan_p);

    for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
        bsg_cover_realign_ring #(
            .chan_width_p(chan_width_p),
            .max_depth_p (max_depth_p)
        ) ring (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .wptr_i     (wptr_q),
            .v_i        (v_i),
            .data_i     (data_i[c*chan_width_p +: chan_width_p]),
            .cfg_we_i   (cfgAccept && (cfg_chan_i == chan_w_lp'(c))),
            .cfg_depth_i(cfg_depth_i),
            .data_o     (data_o[c*chan_width_p +: chan_width_p]),
            .depth_o    (chanDepth[c])
        );
    end

    // Deepest channel decides how much history must exist before v_o.
    always_comb begin
        maxDepth = '0;
        for (int c = 0; c < num_chan_p; c++) begin
            if (chanDepth[c] > maxDepth) begin
                maxDepth = chanDepth[c];
            end
        end
    end

    // A config write restarts the fill count even if a beat arrives in the
    // same cycle; that beat was produced under the old depth and is not
    // counted toward the new history.
    always_comb begin
        wptr_d    = wptr_q;
        fillCnt_d = fillCnt_q;
        if (v_i) begin
            wptr_d = (wptr_q == ptr_w_lp'(max_depth_p - 1))
                   ? '0 : wptr_q + ptr_w_lp'(1);
        end
        if (cfgAccept) begin
            fillCnt_d = '0;
        end else if (v_i && (fillCnt_q != depth_w_lp'(max_depth_p))) begin
            fillCnt_d = fillCnt_q + depth_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q    <= '0;
            fillCnt_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            fillCnt_q <= fillCnt_d;
        end
    end

    assign primed_o = (fillCnt_q >= maxDepth);
    assign v_o      = v_i & primed_o;

endmodule

// File: tb/tb_bsg_cover_realign_dyn.sv
// tb_bsg_cover_realign_dyn
//   Self-checking bench for bsg_cover_realign_dyn. A behavioural model keeps
//   the full list of accepted beats and the programmed depths; expected
//   outputs are looked up from that history. A second, 3-channel instance
//   exercises config writes to a nonexistent channel.

module tb_bsg_cover_realign_dyn;

    logic        clk = 1'b0;
    logic        reset_i, cfg_v_i, v_i;
    logic [1:0]  cfg_chan_i;
    logic [3:0]  cfg_depth_i;
    logic [31:0] data_i;
    logic        v_o, primed_o;
    logic [31:0] data_o;

    logic        reset2, cfgV2, v2;
    logic [1:0]  cfgChan2;
    logic [3:0]  cfgDepth2;
    logic [23:0] data2In;
    logic        v2Out, primed2Out;
    logic [23:0] data2Out;

    int nCompared = 0;
    int nFailed   = 0;

    // Reference model state
    int          depthM [4];
    logic [31:0] hist [$];
    int          beatsSinceCfg;
    logic [31:0] expData, expMask;
    logic        expV, expPrimed;

    always #5 clk = ~clk;

    bsg_cover_realign_dyn #(
        .num_chan_p(4), .chan_width_p(8), .max_depth_p(8)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .cfg_v_i(cfg_v_i),
        .cfg_chan_i(cfg_chan_i), .cfg_depth_i(cfg_depth_i), .v_i(v_i),
        .data_i(data_i), .v_o(v_o), .data_o(data_o), .primed_o(primed_o)
    );

    bsg_cover_realign_dyn #(
        .num_chan_p(3), .chan_width_p(8), .max_depth_p(8)
    ) dut2 (
        .clk_i(clk), .reset_i(reset2), .cfg_v_i(cfgV2),
        .cfg_chan_i(cfgChan2), .cfg_depth_i(cfgDepth2), .v_i(v2),
        .data_i(data2In), .v_o(v2Out), .data_o(data2Out), .primed_o(primed2Out)
    );

    // Expected outputs for the inputs currently applied, from model state.
    function automatic void predict();
        int          maxd;
        logic [31:0] h;
        maxd = 0;
        for (int c = 0; c < 4; c++) if (depthM[c] > maxd) maxd = depthM[c];
        expPrimed = (beatsSinceCfg >= maxd);
        expV      = v_i && expPrimed;
        expData   = '0;
        expMask   = '0;
        for (int c = 0; c < 4; c++) begin
            if (depthM[c] == 0) begin
                expData[c*8 +: 8] = data_i[c*8 +: 8];
                expMask[c*8 +: 8] = 8'hff;
            end else if (hist.size() >= depthM[c]) begin
                h = hist[hist.size() - depthM[c]];
                expData[c*8 +: 8] = h[c*8 +: 8];
                expMask[c*8 +: 8] = 8'hff;
            end
        end
    endfunction

    task automatic driveAndPredict(input logic rst, input logic v, input logic [31:0] d,
                                   input logic cv, input logic [1:0] cc, input logic [3:0] cd);
        @(negedge clk);
        reset_i = rst; v_i = v; data_i = d;
        cfg_v_i = cv; cfg_chan_i = cc; cfg_depth_i = cd;
        #2;
        predict();
    endtask

    // Apply the clock edge to the model using the inputs held across it.
    task automatic advance();
        @(posedge clk);
        if (reset_i) begin
            for (int c = 0; c < 4; c++) depthM[c] = 0;
            hist.delete();
            beatsSinceCfg = 0;
        end else begin
            if (v_i) hist.push_back(data_i);
            if (cfg_v_i) begin
                depthM[cfg_chan_i] = (cfg_depth_i > 8) ? 8 : int'(cfg_depth_i);
                beatsSinceCfg = 0;
            end else if (v_i) begin
                beatsSinceCfg++;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            driveAndPredict(1'b1, 1'b1, $urandom, 1'b0, 2'd0, 4'd0);
            advance();
        end
        driveAndPredict(1'b0, 1'b1, 32'h0403_0201, 1'b0, 2'd0, 4'd0);
        nCompared += 3;
        if (v_o !== 1'b1) begin nFailed++; $display("[TB] FAIL reset_v_o got %0b expected 1", v_o); end
        if (primed_o !== 1'b1) begin nFailed++; $display("[TB] FAIL reset_primed got %0b expected 1", primed_o); end
        if (data_o !== 32'h0403_0201) begin nFailed++; $display("[TB] FAIL reset_passthrough got %h expected 04030201", data_o); end
        advance();
    endtask

    task automatic test_static_depths();
        for (int c = 0; c < 4; c++) begin
            driveAndPredict(1'b0, 1'b0, $urandom, 1'b1, 2'(c), 4'(c));
            nCompared++;
            if (v_o !== expV) begin nFailed++; $display("[TB] FAIL cfg_v_o got %0b expected %0b", v_o, expV); end
            advance();
        end
        for (int n = 0; n < 12; n++) begin
            driveAndPredict(1'b0, 1'b1, {4'd3, 4'(n), 4'd2, 4'(n), 4'd1, 4'(n), 4'd0, 4'(n)},
                            1'b0, 2'd0, 4'd0);
            nCompared += 3;
            if (v_o !== expV) begin nFailed++; $display("[TB] FAIL static_v_o beat %0d got %0b expected %0b", n, v_o, expV); end
            if (primed_o !== expPrimed) begin nFailed++; $display("[TB] FAIL static_primed beat %0d got %0b expected %0b", n, primed_o, expPrimed); end
            if ((data_o & expMask) !== (expData & expMask)) begin nFailed++; $display("[TB] FAIL static_data beat %0d got %h expected %h mask %h", n, data_o, expData, expMask); end
            advance();
        end
    endtask

    task automatic test_stalls();
        driveAndPredict(1'b0, 1'b0, $urandom, 1'b1, 2'd3, 4'd3);
        advance();
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int g = 0; g < 5; g++) begin
                    driveAndPredict(1'b0, 1'b0, $urandom, 1'b0, 2'd0, 4'd0);
                    nCompared += 2;
                    if (v_o !== 1'b0) begin nFailed++; $display("[TB] FAIL gap_v_o got %0b expected 0", v_o); end
                    if ((data_o & expMask) !== (expData & expMask)) begin nFailed++; $display("[TB] FAIL gap_data got %h expected %h mask %h", data_o, expData, expMask); end
                    advance();
                end
            end
            driveAndPredict(1'b0, 1'b1, $urandom, 1'b0, 2'd0, 4'd0);
            nCompared += 2;
            if (v_o !== expV) begin nFailed++; $display("[TB] FAIL stall_v_o beat %0d got %0b expected %0b", n, v_o, expV); end
            if ((data_o & expMask) !== (expData & expMask)) begin nFailed++; $display("[TB] FAIL stall_data beat %0d got %h expected %h mask %h", n, data_o, expData, expMask); end
            advance();
        end
    endtask

    task automatic test_max_depth();
        driveAndPredict(1'b1, 1'b0, $urandom, 1'b0, 2'd0, 4'd0);
        advance();
        driveAndPredict(1'b0, 1'b0, $urandom, 1'b1, 2'd0, 4'd8);
        advance();
        for (int n = 0; n < 20; n++) begin
            driveAndPredict(1'b0, 1'b1, $urandom, 1'b0, 2'd0, 4'd0);
            nCompared += 3;
            if (primed_o !== (n >= 8)) begin nFailed++; $display("[TB] FAIL max_primed beat %0d got %0b expected %0b", n, primed_o, (n >= 8)); end
            if (v_o !== expV) begin nFailed++; $display("[TB] FAIL max_v_o beat %0d got %0b expected %0b", n, v_o, expV); end
            if ((data_o & expMask) !== (expData & expMask)) begin nFailed++; $display("[TB] FAIL max_data beat %0d got %h expected %h mask %h", n, data_o, expData, expMask); end
            advance();
        end
    endtask

    task automatic test_reconfig();
        for (int c = 0; c < 4; c++) begin
            driveAndPredict(1'b0, 1'b0, $urandom, 1'b1, 2'(c), 4'(c));
            advance();
        end
        for (int n = 0; n < 24; n++) begin
            // beat 6: chan1 -> 5 together with a beat; beat 14: chan2 -> 12 (clamped)
            driveAndPredict(1'b0, 1'b1, $urandom, (n == 6) || (n == 14),
                            (n == 6) ? 2'd1 : 2'd2, (n == 6) ? 4'd5 : 4'd12);
            nCompared += 3;
            if (v_o !== expV) begin nFailed++; $display("[TB] FAIL reconfig_v_o beat %0d got %0b expected %0b", n, v_o, expV); end
            if (primed_o !== expPrimed) begin nFailed++; $display("[TB] FAIL reconfig_primed beat %0d got %0b expected %0b", n, primed_o, expPrimed); end
            if ((data_o & expMask) !== (expData & expMask)) begin nFailed++; $display("[TB] FAIL reconfig_data beat %0d got %h expected %h mask %h", n, data_o, expData, expMask); end
            advance();
        end
    endtask

    task automatic test_midstream_reset();
        driveAndPredict(1'b1, 1'b1, $urandom, 1'b0, 2'd0, 4'd0);
        advance();
        for (int n = 0; n < 4; n++) begin
            driveAndPredict(1'b0, 1'(n != 2), $urandom, 1'b0, 2'd0, 4'd0);
            nCompared += 3;
            if (v_o !== v_i) begin nFailed++; $display("[TB] FAIL rst_v_o beat %0d got %0b expected %0b", n, v_o, v_i); end
            if (primed_o !== expPrimed) begin nFailed++; $display("[TB] FAIL rst_primed beat %0d got %0b expected %0b", n, primed_o, expPrimed); end
            if (data_o !== data_i) begin nFailed++; $display("[TB] FAIL rst_passthrough beat %0d got %h expected %h", n, data_o, data_i); end
            advance();
        end
    endtask

    task automatic test_cfg_out_of_range();
        logic [23:0] beats [3];
        @(negedge clk);
        reset2 = 1'b0; cfgV2 = 1'b1; cfgChan2 = 2'd0; cfgDepth2 = 4'd2; v2 = 1'b0;
        @(negedge clk);
        cfgV2 = 1'b0;
        for (int n = 0; n < 3; n++) begin
            v2 = 1'b1; data2In = 24'($urandom); beats[n] = data2In;
            @(negedge clk);
        end
        v2 = 1'b0;
        #2;
        nCompared++;
        if (primed2Out !== 1'b1) begin nFailed++; $display("[TB] FAIL oor_primed_before got %0b expected 1", primed2Out); end
        @(negedge clk);
        cfgV2 = 1'b1; cfgChan2 = 2'd3; cfgDepth2 = 4'd5; v2 = 1'b1; data2In = 24'($urandom);
        @(negedge clk);
        cfgV2 = 1'b0; v2 = 1'b1; data2In = 24'($urandom);
        #2;
        nCompared += 3;
        if (primed2Out !== 1'b1) begin nFailed++; $display("[TB] FAIL oor_primed_after got %0b expected 1", primed2Out); end
        if (v2Out !== 1'b1) begin nFailed++; $display("[TB] FAIL oor_v_o got %0b expected 1", v2Out); end
        if (data2Out[23:8] !== data2In[23:8]) begin nFailed++; $display("[TB] FAIL oor_passthrough got %h expected %h", data2Out[23:8], data2In[23:8]); end
        @(negedge clk);
        v2 = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; v_i = 1'b0; data_i = '0;
        cfg_v_i = 1'b0; cfg_chan_i = '0; cfg_depth_i = '0;
        reset2 = 1'b1; cfgV2 = 1'b0; cfgChan2 = '0; cfgDepth2 = '0; v2 = 1'b0; data2In = '0;
        for (int c = 0; c < 4; c++) depthM[c] = 0;
        beatsSinceCfg = 0;

        test_reset();
        test_static_depths();
        test_stalls();
        test_max_depth();
        test_reconfig();
        test_midstream_reset();
        test_cfg_out_of_range();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
